// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a LIFO return-address stack.
// Each enabled cycle picks the next PC from {JUMP,SUB}: sequential step,
// absolute jump, subroutine call (push PC+1) or return (pop). Stack status
// is reported through SP, EMPTY/FULL and sticky overflow/underflow flags.
module pc_stack_unit #(
  parameter int                 ADDR_W       = 11,
  parameter int                 DEPTH        = 8,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       EN,
  input  logic                       JUMP,
  input  logic                       SUB,
  input  logic [ADDR_W-1:0]          TARGET,
  output logic [ADDR_W-1:0]          PC,
  output logic [$clog2(DEPTH+1)-1:0] SP,
  output logic                       STACK_EMPTY,
  output logic                       STACK_FULL,
  output logic                       STACK_OVF,
  output logic                       STACK_UNF
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  // {JUMP,SUB} encodings as delivered by the branch-decision block
  typedef enum logic [1:0] {
    ACT_NEXT = 2'b00,
    ACT_RET  = 2'b01,
    ACT_JMP  = 2'b10,
    ACT_BSR  = 2'b11
  } act_e;

  // Sequential successor of an address; wraps all-ones back to zero.
  function automatic logic [ADDR_W-1:0] pc_wrap_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // Registered state
  logic [ADDR_W-1:0] pc_p1;
  logic [SP_W-1:0]   sp_p1;
  logic              ovf_p1;
  logic              unf_p1;
  logic [ADDR_W-1:0] stack_mem [DEPTH];

  // Next-state values
  logic [ADDR_W-1:0] pc_nxt;
  logic [SP_W-1:0]   sp_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              push_en;
  logic [ADDR_W-1:0] push_data;

  act_e              act;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              sp_is_full;
  logic              sp_is_empty;

  assign act         = act_e'({JUMP, SUB});
  assign pc_inc      = pc_wrap_inc(pc_p1);
  assign sp_is_full  = (sp_p1 == SP_MAX);
  assign sp_is_empty = (sp_p1 == '0);
  // Push slot is SP itself (only used while SP<DEPTH); pop slot is SP-1.
  assign wr_idx      = IDX_W'(sp_p1);
  assign rd_idx      = IDX_W'(sp_p1 - SP_W'(1));
  assign stack_top   = stack_mem[rd_idx];

  // Decode the retired instruction's control action into next PC/SP/flags
  always_comb begin
    pc_nxt    = pc_p1;
    sp_nxt    = sp_p1;
    ovf_nxt   = ovf_p1;
    unf_nxt   = unf_p1;
    push_en   = 1'b0;
    push_data = pc_inc;
    if (EN) begin
      unique case (act)
        ACT_NEXT: pc_nxt = pc_inc;
        ACT_JMP:  pc_nxt = TARGET;
        ACT_BSR: begin
          if (sp_is_full) begin
            // Call suppressed: execution falls through to the next address.
            ovf_nxt = 1'b1;
            pc_nxt  = pc_inc;
          end else begin
            push_en = 1'b1;
            sp_nxt  = sp_p1 + SP_W'(1);
            pc_nxt  = TARGET;
          end
        end
        ACT_RET: begin
          if (sp_is_empty) begin
            unf_nxt = 1'b1;
            pc_nxt  = pc_inc;
          end else begin
            sp_nxt  = sp_p1 - SP_W'(1);
            pc_nxt  = stack_top;
          end
        end
        default: pc_nxt = pc_inc;
      endcase
    end
  end

  // ---- stage boundary: control state register (PC, SP, sticky flags) ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_p1  <= RESET_VECTOR;
      sp_p1  <= '0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      pc_p1  <= pc_nxt;
      sp_p1  <= sp_nxt;
      ovf_p1 <= ovf_nxt;
      unf_p1 <= unf_nxt;
    end
  end

  // Return-address storage; contents are not cleared by reset
  always_ff @(posedge CLK) begin
    if (push_en && !RESET) begin
      stack_mem[wr_idx] <= push_data;
    end
  end

  assign PC          = pc_p1;
  assign SP          = sp_p1;
  assign STACK_EMPTY = sp_is_empty;
  assign STACK_FULL  = sp_is_full;
  assign STACK_OVF   = ovf_p1;
  assign STACK_UNF   = unf_p1;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Testbench for pc_stack_unit: directed sequences plus random traffic,
// checked by a queue-based scoreboard against a behavioural model.
module tb_pc_stack_unit;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 8;
  localparam int SP_W   = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] RV = 11'h000;

  logic              CLK;
  logic              RESET;
  logic              EN;
  logic              JUMP;
  logic              SUB;
  logic [ADDR_W-1:0] TARGET;
  logic [ADDR_W-1:0] PC;
  logic [SP_W-1:0]   SP;
  logic              STACK_EMPTY;
  logic              STACK_FULL;
  logic              STACK_OVF;
  logic              STACK_UNF;

  pc_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .JUMP(JUMP), .SUB(SUB), .TARGET(TARGET),
    .PC(PC), .SP(SP), .STACK_EMPTY(STACK_EMPTY), .STACK_FULL(STACK_FULL),
    .STACK_OVF(STACK_OVF), .STACK_UNF(STACK_UNF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int                step_id;
    logic [ADDR_W-1:0] pc;
    int                sp;
    logic              ovf;
    logic              unf;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   step_cnt    = 0;

  // Behavioural model: PC, a queue used as the return stack, sticky flags
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_stk[$];
  logic              m_ovf;
  logic              m_unf;

  task automatic model_apply(input logic r, input logic e, input logic j,
                             input logic s, input logic [ADDR_W-1:0] t);
    logic [ADDR_W-1:0] nxt;
    nxt = m_pc + 11'd1;
    if (r) begin
      m_pc = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (e) begin
      if (j && s) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(nxt);
          m_pc = t;
        end else begin
          m_ovf = 1'b1;
          m_pc  = nxt;
        end
      end else if (j) begin
        m_pc = t;
      end else if (s) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_unf = 1'b1;
          m_pc  = nxt;
        end
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge
  task automatic step(input logic r, input logic e, input logic j,
                      input logic s, input logic [ADDR_W-1:0] t);
    exp_t x;
    RESET = r; EN = e; JUMP = j; SUB = s; TARGET = t;
    model_apply(r, e, j, s, t);
    step_cnt++;
    x.step_id = step_cnt;
    x.pc      = m_pc;
    x.sp      = m_stk.size();
    x.ovf     = m_ovf;
    x.unf     = m_unf;
    sb.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: each edge retires one queued expectation; sample 2 units later
  always @(posedge CLK) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      #2;
      vectors++;
      if (PC !== x.pc) begin
        miscompares++;
        $display("FAIL pc step %0d: got %h expected %h", x.step_id, PC, x.pc);
      end
      if (SP !== SP_W'(x.sp)) begin
        miscompares++;
        $display("FAIL sp step %0d: got %0d expected %0d", x.step_id, SP, x.sp);
      end
      if (STACK_EMPTY !== (x.sp == 0)) begin
        miscompares++;
        $display("FAIL empty step %0d: got %b expected %b", x.step_id, STACK_EMPTY, x.sp == 0);
      end
      if (STACK_FULL !== (x.sp == DEPTH)) begin
        miscompares++;
        $display("FAIL full step %0d: got %b expected %b", x.step_id, STACK_FULL, x.sp == DEPTH);
      end
      if (STACK_OVF !== x.ovf) begin
        miscompares++;
        $display("FAIL ovf step %0d: got %b expected %b", x.step_id, STACK_OVF, x.ovf);
      end
      if (STACK_UNF !== x.unf) begin
        miscompares++;
        $display("FAIL unf step %0d: got %b expected %b", x.step_id, STACK_UNF, x.unf);
      end
    end
  end

  initial begin
    m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;
    RESET = 1'b1; EN = 1'b0; JUMP = 1'b0; SUB = 1'b0; TARGET = '0;

    // Reset, then three sequential steps, then wrap at all-ones
    step(1, 0, 0, 0, 11'h000);
    repeat (3) step(0, 1, 0, 0, 11'h000);
    step(0, 1, 1, 0, 11'h7FF);
    step(0, 1, 0, 0, 11'h000);

    // PC=5 then jump, then EN=0 with JUMP held
    step(1, 0, 0, 0, 11'h000);
    repeat (5) step(0, 1, 0, 0, 11'h000);
    step(0, 1, 1, 0, 11'h120);
    repeat (4) step(0, 0, 1, 0, 11'h555);

    // Nested calls and returns
    step(0, 1, 1, 0, 11'h010);
    step(0, 1, 1, 1, 11'h200);
    step(0, 1, 1, 1, 11'h300);
    step(0, 1, 0, 1, 11'h000);
    step(0, 1, 0, 1, 11'h000);

    // Fill the stack, overflow at PC=0x40, then unwind
    for (int i = 0; i < 7; i++) step(0, 1, 1, 1, 11'(11'h100 + 11'(i * 16)));
    step(0, 1, 1, 1, 11'h040);
    step(0, 1, 1, 1, 11'h500);
    step(0, 1, 0, 0, 11'h000);
    repeat (8) step(0, 1, 0, 1, 11'h000);

    // Underflow from reset, flag sticky through NEXT/JMP
    step(1, 1, 1, 1, 11'h123);
    step(0, 1, 0, 1, 11'h000);
    step(0, 1, 0, 0, 11'h000);
    step(0, 1, 1, 0, 11'h2AA);
    step(0, 1, 0, 1, 11'h000);

    // SP=3, reset coincident with an enabled call
    repeat (3) step(0, 1, 1, 1, 11'h0F0);
    step(1, 1, 1, 1, 11'h3FF);
    step(0, 1, 0, 0, 11'h000);

    // Random traffic, biased toward calls/returns so both stack ends are reached
    for (int i = 0; i < 3000; i++) begin
      logic r, e, j, s;
      int   sel;
      r   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      j   = (sel >= 4 && sel <= 8) || sel == 9;
      s   = (sel >= 6);
      if (sel == 9) s = 1'b0;
      if (sel == 3) begin j = 1'b0; s = 1'b1; end
      step(r, e, j, s, 11'($urandom));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    #5;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
